mux_sel_arbiter: RTL and testbench



---
 rtl/mux_sel_arbiter.sv | 131 +++++++++++++
 tb/tb_mux_sel_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter for two single-bit requesters feeding a one-entry
// output stage (din_0/din_1/sel) of a downstream 2:1 mux, with a burst limit.
module mux_sel_arbiter #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_0,
  input  logic data_0,
  input  logic req_1,
  input  logic data_1,
  output logic grant_0,
  output logic grant_1,
  input  logic out_ready,
  output logic out_valid,
  output logic sel,
  output logic din_0,
  output logic din_1
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_t           state_reg, state_next;
  logic             last_reg, last_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             out_valid_reg;
  logic             sel_reg;
  logic             din_0_reg, din_1_reg;

  logic slot_free;
  logic acc_0, acc_1;
  logic at_limit;

  // Grants depend only on registered state, so reset clears them at once.
  assign slot_free = !out_valid_reg | out_ready;
  assign grant_0   = (state_reg == GNT0) & slot_free;
  assign grant_1   = (state_reg == GNT1) & slot_free;
  assign acc_0     = grant_0 & req_0;
  assign acc_1     = grant_1 & req_1;
  assign at_limit  = (cnt_reg == CNT_LAST);

  always_comb begin
    state_next = state_reg;
    last_next  = last_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (req_0 && req_1) begin
          state_next = last_reg ? GNT0 : GNT1;
          cnt_next   = '0;
        end else if (req_0) begin
          state_next = GNT0;
          cnt_next   = '0;
        end else if (req_1) begin
          state_next = GNT1;
          cnt_next   = '0;
        end
      end
      GNT0: begin
        if (!req_0 || (acc_0 && at_limit)) begin
          last_next = 1'b0;
          cnt_next  = '0;
          if (req_1)      state_next = GNT1;
          else if (req_0) state_next = GNT0;
          else            state_next = IDLE;
        end else if (acc_0) begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      GNT1: begin
        if (!req_1 || (acc_1 && at_limit)) begin
          last_next = 1'b1;
          cnt_next  = '0;
          if (req_0)      state_next = GNT0;
          else if (req_1) state_next = GNT1;
          else            state_next = IDLE;
        end else if (acc_1) begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      last_reg  <= 1'b1;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
      cnt_reg   <= cnt_next;
    end
  end

  // A new accept reloads the stage even when it is being consumed this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      sel_reg       <= 1'b0;
      din_0_reg     <= 1'b0;
      din_1_reg     <= 1'b0;
    end else begin
      if (acc_0 || acc_1) begin
        out_valid_reg <= 1'b1;
        sel_reg       <= acc_1;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
      if (acc_0) din_0_reg <= data_0;
      if (acc_1) din_1_reg <= data_1;
    end
  end

  assign out_valid = out_valid_reg;
  assign sel       = sel_reg;
  assign din_0     = din_0_reg;
  assign din_1     = din_1_reg;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Bench for mux_sel_arbiter: table of per-cycle inputs and expected grants,
// output stage checked against a beat scoreboard; plus reset and alternation runs.
module tb_mux_sel_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  logic req_0, data_0, req_1, data_1, out_ready;
  logic grant_0, grant_1, out_valid, sel, din_0, din_1;
  logic a_req_0, a_data_0, a_req_1, a_data_1, a_ready;
  logic a_grant_0, a_grant_1, a_valid, a_sel, a_din_0, a_din_1;

  always #5 clk = ~clk;

  mux_sel_arbiter #(.HOLD_CYCLES(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_0(req_0), .data_0(data_0), .req_1(req_1), .data_1(data_1),
    .grant_0(grant_0), .grant_1(grant_1), .out_ready(out_ready),
    .out_valid(out_valid), .sel(sel), .din_0(din_0), .din_1(din_1)
  );

  mux_sel_arbiter #(.HOLD_CYCLES(1), .CNT_W(4)) dut_alt (
    .clk(clk), .rst_n(rst_n),
    .req_0(a_req_0), .data_0(a_data_0), .req_1(a_req_1), .data_1(a_data_1),
    .grant_0(a_grant_0), .grant_1(a_grant_1), .out_ready(a_ready),
    .out_valid(a_valid), .sel(a_sel), .din_0(a_din_0), .din_1(a_din_1)
  );

  typedef struct {
    logic r0, d0, r1, d1, rdy;
    logic g0, g1;
  } vec_t;

  typedef struct packed {
    logic s;
    logic d;
  } beat_t;

  localparam int NVEC = 30;
  vec_t  tbl [NVEC];
  beat_t sb_q [$];
  int    total = 0;
  int    bad   = 0;
  logic  exp_valid, exp_sel, exp_din_0, exp_din_1, prev_rdy;

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic setv(input int k, input logic r0, input logic d0, input logic r1,
                      input logic d1, input logic rdy, input logic g0, input logic g1);
    tbl[k].r0 = r0; tbl[k].d0 = d0; tbl[k].r1 = r1; tbl[k].d1 = d1;
    tbl[k].rdy = rdy; tbl[k].g0 = g0; tbl[k].g1 = g1;
  endtask

  // Retire the beat accepted last cycle (if any) and compare the output stage.
  task automatic check_stage(input string tag);
    beat_t b;
    if (sb_q.size() > 0) begin
      b = sb_q.pop_front();
      exp_valid = 1'b1;
      exp_sel   = b.s;
      if (b.s) exp_din_1 = b.d;
      else     exp_din_0 = b.d;
    end else if (prev_rdy) begin
      exp_valid = 1'b0;
    end
    chk({tag, ".out_valid"}, out_valid, exp_valid);
    chk({tag, ".sel"},       sel,       exp_sel);
    chk({tag, ".din_0"},     din_0,     exp_din_0);
    chk({tag, ".din_1"},     din_1,     exp_din_1);
  endtask

  initial begin
    rst_n = 1'b0;
    {req_0, data_0, req_1, data_1, out_ready} = '0;
    {a_req_0, a_data_0, a_req_1, a_data_1, a_ready} = '0;
    {exp_valid, exp_sel, exp_din_0, exp_din_1, prev_rdy} = '0;

    // Tie, 4-beat burst, hand-over, backpressure, request drop, single requester.
    setv(0, 1,0,1,0,1, 0,0);
    setv(1, 1,1,1,0,1, 1,0);
    setv(2, 1,0,1,0,1, 1,0);
    setv(3, 1,1,1,1,1, 1,0);
    setv(4, 1,1,1,0,1, 1,0);
    setv(5, 1,0,1,1,1, 0,1);
    setv(6, 1,1,1,0,1, 0,1);
    for (int k = 7; k <= 11; k++) setv(k, 1,0,1,1,0, 0,0);
    setv(12, 1,0,1,1,1, 0,1);
    setv(13, 1,1,1,0,1, 0,1);
    setv(14, 1,0,1,1,1, 1,0);
    setv(15, 0,1,1,1,1, 1,0);
    setv(16, 0,0,0,1,1, 0,1);
    setv(17, 0,0,1,0,1, 0,0);
    for (int k = 18; k <= 26; k++) setv(k, 0,0,1,logic'(k % 2),1, 0,1);
    setv(27, 0,0,0,1,1, 0,1);
    setv(28, 1,1,1,1,1, 0,0);
    setv(29, 1,1,1,0,1, 1,0);

    repeat (2) @(posedge clk);
    #1;
    chk("rst.grant_0", grant_0, 1'b0);
    chk("rst.grant_1", grant_1, 1'b0);
    check_stage("rst");
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < NVEC; k++) begin
      @(posedge clk);
      #1;
      {req_0, data_0, req_1, data_1, out_ready} =
        {tbl[k].r0, tbl[k].d0, tbl[k].r1, tbl[k].d1, tbl[k].rdy};
      #1;
      check_stage($sformatf("row%0d", k));
      chk($sformatf("row%0d.grant_0", k), grant_0, tbl[k].g0);
      chk($sformatf("row%0d.grant_1", k), grant_1, tbl[k].g1);
      if (tbl[k].g0 && tbl[k].r0) sb_q.push_back({1'b0, tbl[k].d0});
      if (tbl[k].g1 && tbl[k].r1) sb_q.push_back({1'b1, tbl[k].d1});
      prev_rdy = tbl[k].rdy;
      $display("row %0d req=%b%b rdy=%b grant=%b%b valid=%b sel=%b din=%b%b",
               k, req_1, req_0, out_ready, grant_1, grant_0, out_valid, sel, din_1, din_0);
    end

    // Reset mid-burst: stage is full, then rst_n drops between clock edges.
    @(posedge clk);
    #2;
    check_stage("pre_rst");
    rst_n = 1'b0;
    #1;
    chk("midrst.out_valid", out_valid, 1'b0);
    chk("midrst.sel",       sel,       1'b0);
    chk("midrst.din_0",     din_0,     1'b0);
    chk("midrst.din_1",     din_1,     1'b0);
    chk("midrst.grant_0",   grant_0,   1'b0);
    chk("midrst.grant_1",   grant_1,   1'b0);
    $display("mid-burst reset valid=%b sel=%b din=%b%b grant=%b%b",
             out_valid, sel, din_1, din_0, grant_1, grant_0);
    {req_0, req_1} = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // HOLD_CYCLES=1, both requesting: strict 0,1,0,1 alternation.
    @(posedge clk);
    #1;
    {a_req_0, a_data_0, a_req_1, a_data_1, a_ready} = 5'b1_1_1_0_1;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk);
      #2;
      chk($sformatf("alt%0d.grant_0", k), a_grant_0, logic'(k % 2 == 1));
      chk($sformatf("alt%0d.grant_1", k), a_grant_1, logic'(k >= 2 && k % 2 == 0));
      if (k >= 2) begin
        chk($sformatf("alt%0d.out_valid", k), a_valid, 1'b1);
        chk($sformatf("alt%0d.sel", k),       a_sel,   logic'(k % 2 == 1));
        chk($sformatf("alt%0d.din_0", k),     a_din_0, 1'b1);
        chk($sformatf("alt%0d.din_1", k),     a_din_1, 1'b0);
      end
      $display("alt %0d grant=%b%b valid=%b sel=%b din=%b%b",
               k, a_grant_1, a_grant_0, a_valid, a_sel, a_din_1, a_din_0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
